// File: rtl/cdc_event_scheduler.sv
// Source-domain scheduler sharing one flag crossing between N_REQ requesters.
// Round-robin arbitration, one single-cycle flag per event, ID/payload held
// until ack or timeout, then a guard gap so successive flags stay separable
// in the destination synchronizer.
module cdc_event_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    flag_o,
  output logic [ID_W-1:0]         ev_id_o,
  output logic [DATA_W-1:0]       ev_data_o,
  input  logic                    ack_i,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic                    busy_o,
  output logic [7:0]              err_cnt_o
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

  state_t              state, stateNext;
  logic [ID_W-1:0]     rrPtr, rrNext;
  logic [TMR_W-1:0]    timer, timerNext;
  logic [GAP_W-1:0]    gapCnt, gapNext;
  logic [N_REQ-1:0]    grantNext;
  logic                flagNext, doneNext, timeoutNext;
  logic [ID_W-1:0]     evIdNext;
  logic [DATA_W-1:0]   evDataNext;
  logic [7:0]          errNext;
  logic                pickFound;
  logic [ID_W-1:0]     pickIdx;
  logic [DATA_W-1:0]   pickData;

  // Lost-event counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin pick: first set request searching upward from rrPtr+1, wrapping.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!pickFound && (k == (int'(rrPtr) + i) % N_REQ) && req_i[k]) begin
          pickFound = 1'b1;
          pickIdx   = ID_W'(k);
        end
      end
    end
  end

  // Payload mux for the picked requester.
  always_comb begin
    pickData = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == pickIdx) pickData = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    stateNext   = state;
    rrNext      = rrPtr;
    timerNext   = timer;
    gapNext     = gapCnt;
    flagNext    = 1'b0;
    grantNext   = '0;
    evIdNext    = ev_id_o;
    evDataNext  = ev_data_o;
    doneNext    = 1'b0;
    timeoutNext = 1'b0;
    errNext     = err_cnt_o;
    case (state)
      IDLE: begin
        if (pickFound) begin
          evIdNext   = pickIdx;
          evDataNext = pickData;
          flagNext   = 1'b1;
          grantNext  = N_REQ'(1) << pickIdx;
          rrNext     = pickIdx;
          timerNext  = '0;
          stateNext  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timerNext = timer + TMR_W'(1);
        // Ack has priority over a simultaneous timeout expiry.
        if (ack_i) begin
          doneNext  = 1'b1;
          gapNext   = '0;
          stateNext = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (timer == TMR_LAST) begin
          timeoutNext = 1'b1;
          errNext     = satInc(err_cnt_o);
          gapNext     = '0;
          stateNext   = (GAP_CYC == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) stateNext = IDLE;
        else                    gapNext   = gapCnt + GAP_W'(1);
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= ID_W'(N_REQ - 1);
      timer     <= '0;
      gapCnt    <= '0;
      flag_o    <= 1'b0;
      grant_o   <= '0;
      ev_id_o   <= '0;
      ev_data_o <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state     <= stateNext;
      rrPtr     <= rrNext;
      timer     <= timerNext;
      gapCnt    <= gapNext;
      flag_o    <= flagNext;
      grant_o   <= grantNext;
      ev_id_o   <= evIdNext;
      ev_data_o <= evDataNext;
      done_o    <= doneNext;
      timeout_o <= timeoutNext;
      err_cnt_o <= errNext;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed bench for cdc_event_scheduler (N_REQ=4, DATA_W=8, TIMEOUT=64, GAP_CYC=3).
module tb_cdc_event_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic [3:0]  grant_o;
  logic        flag_o;
  logic [1:0]  ev_id_o;
  logic [7:0]  ev_data_o;
  logic        ack_i;
  logic        done_o;
  logic        timeout_o;
  logic        busy_o;
  logic [7:0]  err_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdc_event_scheduler #(
    .N_REQ(4), .ID_W(2), .DATA_W(8), .TIMEOUT(64), .GAP_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
    .grant_o(grant_o), .flag_o(flag_o), .ev_id_o(ev_id_o), .ev_data_o(ev_data_o),
    .ack_i(ack_i), .done_o(done_o), .timeout_o(timeout_o), .busy_o(busy_o),
    .err_cnt_o(err_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 20 && busy_o; c++) tick();
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL %s_idle_wait busy=%b exp=0", tag, busy_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = '0; req_data_i = '0; ack_i = 1'b0;
    tick(); tick();
    checks++; if ({flag_o, grant_o} !== 5'd0) begin failures++; $display("FAIL reset_flag_grant got=%b exp=0", {flag_o, grant_o}); end
    checks++; if ({ev_id_o, ev_data_o} !== 10'd0) begin failures++; $display("FAIL reset_ev got=%h exp=0", {ev_id_o, ev_data_o}); end
    checks++; if ({done_o, timeout_o, busy_o} !== 3'd0) begin failures++; $display("FAIL reset_status got=%b exp=000", {done_o, timeout_o, busy_o}); end
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt_o); end
    rst_n = 1'b1;
    tick();
    checks++; if ({flag_o, busy_o} !== 2'b00) begin failures++; $display("FAIL release_no_flag got=%b exp=00", {flag_o, busy_o}); end
  endtask

  task automatic test_single();
    req_data_i = 32'h0000_00A5; req_i = 4'b0001;
    tick(); // c0
    checks++; if ({flag_o, grant_o} !== 5'b1_0001) begin failures++; $display("FAIL single_flag got=%b exp=10001", {flag_o, grant_o}); end
    checks++; if ({ev_id_o, ev_data_o} !== {2'd0, 8'hA5}) begin failures++; $display("FAIL single_ev got=%h exp=0a5", {ev_id_o, ev_data_o}); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    req_i = '0; req_data_i = 32'h0000_005A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if ({flag_o, grant_o, done_o} !== 6'd0) begin failures++; $display("FAIL single_quiet_c%0d got=%b exp=0", c, {flag_o, grant_o, done_o}); end
      checks++; if ({ev_id_o, ev_data_o} !== {2'd0, 8'hA5}) begin failures++; $display("FAIL single_hold_c%0d got=%h exp=0a5", c, {ev_id_o, ev_data_o}); end
    end
    tick(); // c5: ack high this cycle
    ack_i = 1'b1;
    tick(); // c6
    ack_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done_o); end
    checks++; if ({ev_id_o, ev_data_o} !== {2'd0, 8'hA5}) begin failures++; $display("FAIL single_gap_hold got=%h exp=0a5", {ev_id_o, ev_data_o}); end
    tick(); tick(); // c8, last gap cycle
    checks++; if ({busy_o, done_o} !== 2'b10) begin failures++; $display("FAIL single_gap_busy got=%b exp=10", {busy_o, done_o}); end
    tick(); // c9
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] expId [5];
    logic [7:0] expData [5];
    int nGrant;
    int lastFlag;
    expId   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    nGrant = 0; lastFlag = -1;
    pulse_reset();
    req_data_i = 32'h4433_2211; req_i = 4'b1111; ack_i = 1'b1;
    for (int c = 0; c < 40 && nGrant < 5; c++) begin
      tick();
      checks++; if (flag_o !== (grant_o != 4'd0)) begin failures++; $display("FAIL rr_flag_vs_grant_c%0d flag=%b grant=%b", c, flag_o, grant_o); end
      if (flag_o) begin
        checks++;
        if (ev_id_o !== expId[nGrant] || grant_o !== (4'b0001 << expId[nGrant])) begin
          failures++; $display("FAIL rr_order_%0d id=%0d grant=%b exp_id=%0d", nGrant, ev_id_o, grant_o, expId[nGrant]);
        end
        checks++; if (ev_data_o !== expData[nGrant]) begin failures++; $display("FAIL rr_data_%0d got=%h exp=%h", nGrant, ev_data_o, expData[nGrant]); end
        if (lastFlag >= 0) begin
          checks++; if (c - lastFlag !== 5) begin failures++; $display("FAIL rr_spacing_%0d got=%0d exp=5", nGrant, c - lastFlag); end
        end
        lastFlag = c;
        nGrant++;
      end
    end
    checks++; if (nGrant !== 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", nGrant); end
    req_i = '0;
    wait_idle("rr");
    ack_i = 1'b0;
  endtask

  task automatic test_timeout();
    int tc;
    tc = -1;
    pulse_reset();
    ack_i = 1'b0; req_i = 4'b0010; req_data_i = 32'h0000_7700;
    tick(); // c0
    checks++; if ({flag_o, ev_id_o, ev_data_o} !== {1'b1, 2'd1, 8'h77}) begin failures++; $display("FAIL to_flag got=%h exp=177", {flag_o, ev_id_o, ev_data_o}); end
    req_i = '0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (timeout_o || done_o) begin tc = c; break; end
    end
    checks++; if (tc !== 64) begin failures++; $display("FAIL to_latency got=%0d exp=64", tc); end
    checks++; if ({timeout_o, done_o} !== 2'b10) begin failures++; $display("FAIL to_pulse got=%b exp=10", {timeout_o, done_o}); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL to_err got=%0d exp=1", err_cnt_o); end
    req_i = 4'b0001; req_data_i = 32'h0000_7733;
    tick(); // c65
    checks++; if ({flag_o, busy_o} !== 2'b01) begin failures++; $display("FAIL to_gap1 got=%b exp=01", {flag_o, busy_o}); end
    ack_i = 1'b1; // stray ack in GAP
    tick(); // c66
    ack_i = 1'b0;
    checks++; if ({done_o, timeout_o, flag_o, busy_o} !== 4'b0001) begin failures++; $display("FAIL to_stray_ack got=%b exp=0001", {done_o, timeout_o, flag_o, busy_o}); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL to_stray_err got=%0d exp=1", err_cnt_o); end
    tick(); // c67
    checks++; if ({flag_o, busy_o} !== 2'b00) begin failures++; $display("FAIL to_idle got=%b exp=00", {flag_o, busy_o}); end
    tick(); // c68
    checks++; if ({flag_o, ev_id_o, ev_data_o} !== {1'b1, 2'd0, 8'h33}) begin failures++; $display("FAIL to_next_flag got=%h exp=033+flag", {flag_o, ev_id_o, ev_data_o}); end
    req_i = '0; ack_i = 1'b1;
    tick(); // c69
    ack_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL to_next_done got=%b exp=1", done_o); end
    wait_idle("to");
  endtask

  task automatic test_ack_at_timeout();
    req_i = 4'b0100; req_data_i = 32'h00C3_0000;
    tick(); // c0
    checks++; if ({flag_o, ev_id_o, ev_data_o} !== {1'b1, 2'd2, 8'hC3}) begin failures++; $display("FAIL race_flag got=%h exp=2c3+flag", {flag_o, ev_id_o, ev_data_o}); end
    req_i = '0;
    for (int c = 1; c <= 63; c++) tick();
    ack_i = 1'b1; // c63: timer is at its last count
    tick(); // c64
    ack_i = 1'b0;
    checks++; if ({done_o, timeout_o} !== 2'b10) begin failures++; $display("FAIL race_pulses got=%b exp=10", {done_o, timeout_o}); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL race_err got=%0d exp=1", err_cnt_o); end
    tick();
    checks++; if ({done_o, timeout_o} !== 2'b00) begin failures++; $display("FAIL race_after got=%b exp=00", {done_o, timeout_o}); end
    wait_idle("race");
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0100; req_data_i = 32'h00E1_0000;
    tick(); // c0
    checks++; if ({flag_o, ev_id_o} !== 3'b110) begin failures++; $display("FAIL mid_flag got=%b exp=110", {flag_o, ev_id_o}); end
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({flag_o, grant_o, busy_o, ev_id_o, ev_data_o} !== 16'd0) begin failures++; $display("FAIL mid_async_clear got=%h exp=0", {flag_o, grant_o, busy_o, ev_id_o, ev_data_o}); end
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL mid_err_clear got=%0d exp=0", err_cnt_o); end
    tick();
    rst_n = 1'b1;
    checks++; if ({flag_o, busy_o} !== 2'b00) begin failures++; $display("FAIL mid_release got=%b exp=00", {flag_o, busy_o}); end
    tick();
    checks++; if ({flag_o, grant_o, ev_id_o, ev_data_o} !== {1'b1, 4'b0100, 2'd2, 8'hE1}) begin failures++; $display("FAIL mid_reissue got=%h", {flag_o, grant_o, ev_id_o, ev_data_o}); end
    rst_n = 1'b0; req_i = 4'b0101;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({grant_o, ev_id_o} !== {4'b0001, 2'd0}) begin failures++; $display("FAIL mid_rr_restart grant=%b id=%0d exp=0001/0", grant_o, ev_id_o); end
    req_i = '0;
  endtask

  task automatic test_saturation();
    int nTo;
    nTo = 0;
    pulse_reset();
    ack_i = 1'b0; req_i = 4'b0001;
    for (int c = 0; c < 25000 && nTo < 300; c++) begin
      tick();
      if (timeout_o) begin
        nTo++;
        if (nTo == 100) begin
          checks++; if (err_cnt_o !== 8'd100) begin failures++; $display("FAIL sat_100 got=%0d exp=100", err_cnt_o); end
        end
        if (nTo == 255) begin
          checks++; if (err_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", err_cnt_o); end
        end
        if (nTo == 256) begin
          checks++; if (err_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_256 got=%0d exp=255", err_cnt_o); end
        end
      end
    end
    req_i = '0;
    checks++; if (nTo !== 300) begin failures++; $display("FAIL sat_count got=%0d exp=300", nTo); end
    checks++; if (err_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", err_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_event_scheduler.md
Name: cdc_event_scheduler

Overview:
Source-domain scheduler that shares one flag clock-domain-crossing channel (toggle synchronizer plus a returning ack crossing) between N_REQ requesters. Arbitrates round-robin and launches one single-cycle flag per event. Holds the event ID and payload stable until the far domain acknowledges or a timeout fires. Enforces a guard gap so consecutive flags never merge in the 3-stage destination synchronizer.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, event ID width; must satisfy 2^ID_W >= N_REQ
DATA_W, 8, payload width per requester
TIMEOUT, 64, WAIT_ACK cycles before an event is declared lost (>=4)
GAP_CYC, 3, idle guard cycles after each completed or timed-out event (0 allowed)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
req_i  in  N_REQ  level request per requester; held high until its grant pulse
req_data_i  in  N_REQ*DATA_W  payload; requester k uses bits [k*DATA_W +: DATA_W]
grant_o  out  N_REQ  one-hot, single-cycle accept pulse
flag_o  out  1  single-cycle pulse into the flag crossing
ev_id_o  out  ID_W  granted requester index, stable from flag_o until leaving WAIT_ACK
ev_data_o  out  DATA_W  latched payload, same stability as ev_id_o
ack_i  in  1  single-cycle ack pulse, already synchronized into clk
done_o  out  1  single-cycle pulse on acknowledged completion
timeout_o  out  1  single-cycle pulse on lost event
busy_o  out  1  high whenever state != IDLE
err_cnt_o  out  8  saturating count of timeouts

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer = N_REQ-1, all outputs 0, timer and gap counters 0. Asserting reset mid-event abandons the event. No flag is emitted on reset release, and pending req_i stays pending.
- States: IDLE, WAIT_ACK, GAP.
- IDLE:
  - If any req_i is set, select the first set bit searching upward from rr+1 with wrap-around.
  - At that edge: register ev_id_o = k, ev_data_o = req_data_i[k], flag_o = 1, grant_o[k] = 1, rr = k, timer = 0. Next state WAIT_ACK.
  - Latency from req_i sampled high to flag_o high is 1 cycle.
- WAIT_ACK:
  - flag_o and grant_o are high only in the first cycle.
  - Timer increments every cycle.
  - ack_i is sampled from the first WAIT_ACK cycle onward.
  - On ack_i: done_o pulses the next cycle, then go to GAP.
  - Else, if timer reaches TIMEOUT-1: timeout_o pulses the next cycle, err_cnt_o increments (saturating at 255), then go to GAP.
  - If ack_i and timeout expiry occur in the same cycle, ack wins: done_o only, no error count.
- GAP:
  - Counts GAP_CYC cycles, then returns to IDLE.
  - If GAP_CYC = 0, go directly to IDLE, so back-to-back events are at least 2 cycles apart.
  - ev_id_o and ev_data_o hold their last values.
- ack_i outside WAIT_ACK is ignored (stray ack from an earlier timed-out event). No state change.
- A requester dropping req_i before its grant is permitted; it is simply not selected.
- Payload is captured once at grant; later changes to req_data_i have no effect.
- Throughput bound per event: 1 + ack latency + GAP_CYC cycles.

Test Plan:
- Single requester: req_i = 0001, data 0xA5, ack 5 cycles after flag. Required: flag_o and grant_o[0] high 1 cycle after req; ev_id_o = 0 and ev_data_o = 0xA5 held until ack; done_o 1 cycle after ack; busy_o low after GAP_CYC = 3 cycles.
- All four requesting continuously, immediate acks. Required: grant order 0,1,2,3,0; exactly one flag per grant; spacing between flags >= 2 + GAP_CYC cycles.
- No ack. Required: timeout_o pulses 64 cycles after flag; err_cnt_o = 1; next request served only after the gap; a stray ack_i during GAP causes no change.
- ack_i arrives on the exact timeout-expiry cycle. Required: done_o = 1, timeout_o = 0, err_cnt_o unchanged.
- rst_n asserted in WAIT_ACK with req_i = 0100 still high. Required: outputs 0 immediately; after release, flag_o reissued for ID 2 with rr restarting so that requester 0 has priority.
- 300 consecutive timeouts. Required: err_cnt_o saturates at 255.
